led_bank_driver: RTL and testbench

Memory-mapped LED bank driver on the CPU peripheral bus, the parametrised successor of the plain 32-bit LED register. It holds an on/off pattern, a per-LED blink mask with a programmable blink half-period, and a global PWM brightness duty. Each cycle it combines these into a registered LED drive vector of configurable polarity. Software sees four word registers with byte-enable writes and combinational readback.

---
 rtl/led_bank_pkg.sv | 27 ++
 rtl/led_blink_timer.sv | 30 +++
 rtl/led_bank_driver.sv | 97 +++++++++
 tb/tb_led_bank_driver.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/led_bank_pkg.sv
// Shared definitions for the LED bank driver: register map and byte-lane merge.
package led_bank_pkg;

    typedef enum logic [1:0] {
        ADDR_DATA   = 2'd0,
        ADDR_MASK   = 2'd1,
        ADDR_PERIOD = 2'd2,
        ADDR_DUTY   = 2'd3
    } reg_addr_e;

    // Replace each byte of old whose enable is set with the matching byte of wd.
    function automatic logic [31:0] byte_merge(
        input logic [31:0] old,
        input logic [31:0] wd,
        input logic [3:0]  be
    );
        logic [31:0] res;
        res = old;
        for (int unsigned k = 0; k < 4; k++) begin
            if (be[k]) begin
                res[8*k +: 8] = wd[8*k +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/led_blink_timer.sv
// Blink phase generator: ph toggles every `period` cycles; period 0 holds ph high.
module led_blink_timer #(
    parameter int BLINK_W = 24
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [BLINK_W-1:0] period,
    input  logic               restart,
    output logic               ph
);

    logic [BLINK_W-1:0] bcnt;

    // Down-counter with reload; a restart wins over a coincident expiry.
    always_ff @(posedge Clock) begin
        if (Reset || restart) begin
            bcnt <= '0;
            ph   <= 1'b1;
        end else if (period == '0) begin
            bcnt <= '0;
            ph   <= 1'b1;
        end else if (bcnt == '0) begin
            bcnt <= period - BLINK_W'(1);
            ph   <= ~ph;
        end else begin
            bcnt <= bcnt - BLINK_W'(1);
        end
    end

endmodule

// File: rtl/led_bank_driver.sv
// Memory-mapped LED bank: pattern, blink mask, blink half-period and PWM duty.
module led_bank_driver
    import led_bank_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int BLINK_W    = 24,
    parameter int PWM_BITS   = 8,
    parameter int ACTIVE_LOW = 1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [1:0]       Addr,
    input  logic             WE,
    input  logic [3:0]       BE,
    input  logic [31:0]      WD,
    output logic [31:0]      RD,
    output logic [WIDTH-1:0] Tube
);

    logic [WIDTH-1:0]    data_q;
    logic [WIDTH-1:0]    mask_q;
    logic [BLINK_W-1:0]  period_q;
    logic [PWM_BITS-1:0] duty_q;
    logic [PWM_BITS-1:0] pcnt;
    logic                ph;
    logic                pon;
    logic                restart;
    logic [WIDTH-1:0]    lit;

    // Register file: byte-enabled writes; bytes above each register width drop out in the cast.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            data_q   <= '0;
            mask_q   <= '0;
            period_q <= '0;
            duty_q   <= '1;
        end else if (WE) begin
            case (Addr)
                ADDR_DATA:   data_q   <= WIDTH'(byte_merge(32'(data_q), WD, BE));
                ADDR_MASK:   mask_q   <= WIDTH'(byte_merge(32'(mask_q), WD, BE));
                ADDR_PERIOD: period_q <= BLINK_W'(byte_merge(32'(period_q), WD, BE));
                default:     duty_q   <= PWM_BITS'(byte_merge(32'(duty_q), WD, BE));
            endcase
        end
    end

    // Any byte written to PERIOD restarts the blink phase.
    always_comb begin
        restart = WE && (Addr == ADDR_PERIOD) && (BE != '0);
    end

    led_blink_timer #(
        .BLINK_W(BLINK_W)
    ) u_blink (
        .Clock  (Clock),
        .Reset  (Reset),
        .period (period_q),
        .restart(restart),
        .ph     (ph)
    );

    // Free-running PWM counter.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PWM_BITS'(1);
        end
    end

    // Combine pattern, blink phase and PWM gate into the lit vector.
    always_comb begin
        pon = (duty_q == '1) || (pcnt < duty_q);
        lit = data_q & (~mask_q | {WIDTH{ph}}) & {WIDTH{pon}};
    end

    // Output register with polarity applied; reset leaves every LED dark.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Tube <= (ACTIVE_LOW != 0) ? '1 : '0;
        end else begin
            Tube <= (ACTIVE_LOW != 0) ? ~lit : lit;
        end
    end

    // Combinational readback, zero-extended to the bus width.
    always_comb begin
        RD = '0;
        case (Addr)
            ADDR_DATA:   RD = 32'(data_q);
            ADDR_MASK:   RD = 32'(mask_q);
            ADDR_PERIOD: RD = 32'(period_q);
            default:     RD = 32'(duty_q);
        endcase
    end

endmodule

// File: tb/tb_led_bank_driver.sv
// Directed self-checking bench for led_bank_driver with default parameters.
module tb_led_bank_driver;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [1:0]  Addr;
    logic        WE;
    logic [3:0]  BE;
    logic [31:0] WD;
    logic [31:0] RD;
    logic [31:0] Tube;

    int checks = 0;
    int errors = 0;

    led_bank_driver #(
        .WIDTH     (32),
        .BLINK_W   (24),
        .PWM_BITS  (8),
        .ACTIVE_LOW(1)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .Addr (Addr),
        .WE   (WE),
        .BE   (BE),
        .WD   (WD),
        .RD   (RD),
        .Tube (Tube)
    );

    always #5 Clock = ~Clock;

    // Drive one write ahead of the next rising edge; returns 1 ns after that edge.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] b);
        @(negedge Clock);
        Addr = a;
        WD   = d;
        BE   = b;
        WE   = 1'b1;
        @(posedge Clock);
        #1;
        WE = 1'b0;
        BE = 4'b0000;
    endtask

    task automatic test_reset();
        logic [31:0] exp_rd [4] = '{32'h0, 32'h0, 32'h0, 32'h0000_00FF};
        Reset = 1'b1;
        WE    = 1'b0;
        BE    = 4'b0000;
        WD    = '0;
        Addr  = 2'd0;
        repeat (3) @(posedge Clock);
        #1;
        Reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            Addr = 2'(i);
            #1;
            checks++;
            if (RD !== exp_rd[i]) begin
                errors++;
                $display("FAIL reset_rd[%0d]: got %h expected %h", i, RD, exp_rd[i]);
            end
        end
        checks++;
        if (Tube !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL reset_tube: got %h expected ffffffff", Tube);
        end
    endtask

    task automatic test_byte_write();
        bus_write(2'd0, 32'hA5A5_0F0F, 4'b0101);
        Addr = 2'd0;
        #1;
        checks++;
        if (RD !== 32'h00A5_000F) begin
            errors++;
            $display("FAIL be_data_rd: got %h expected 00a5000f", RD);
        end
        @(posedge Clock);
        #1;
        checks++;
        if (Tube !== ~32'h00A5_000F) begin
            errors++;
            $display("FAIL be_data_tube: got %h expected %h", Tube, ~32'h00A5_000F);
        end
        bus_write(2'd0, 32'h5A00_0000, 4'b1000);
        Addr = 2'd0;
        #1;
        checks++;
        if (RD !== 32'h5AA5_000F) begin
            errors++;
            $display("FAIL be_top_byte: got %h expected 5aa5000f", RD);
        end
        bus_write(2'd1, 32'hFFFF_FFFF, 4'b0000);
        Addr = 2'd1;
        #1;
        checks++;
        if (RD !== 32'h0) begin
            errors++;
            $display("FAIL be_zero_mask: got %h expected 00000000", RD);
        end
        bus_write(2'd3, 32'h0000_1234, 4'b1111);
        Addr = 2'd3;
        #1;
        checks++;
        if (RD !== 32'h0000_0034) begin
            errors++;
            $display("FAIL duty_trunc: got %h expected 00000034", RD);
        end
        bus_write(2'd2, 32'h1234_5678, 4'b1111);
        Addr = 2'd2;
        #1;
        checks++;
        if (RD !== 32'h0034_5678) begin
            errors++;
            $display("FAIL period_trunc: got %h expected 00345678", RD);
        end
        bus_write(2'd3, 32'h0000_00FF, 4'b0001);
    endtask

    task automatic test_blink();
        // Tube[0] after edges N+1..N+12 where PERIOD=3 was written at edge N.
        logic exp_seq [12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                               1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        bus_write(2'd0, 32'h0000_0001, 4'b1111);
        bus_write(2'd1, 32'h0000_0001, 4'b1111);
        bus_write(2'd2, 32'h0000_0003, 4'b1111);
        for (int m = 0; m < 12; m++) begin
            @(posedge Clock);
            #1;
            checks++;
            if (Tube[0] !== exp_seq[m]) begin
                errors++;
                $display("FAIL blink[%0d]: got %b expected %b", m + 1, Tube[0], exp_seq[m]);
            end
        end
        // Rewrite lands where ph would naturally be 0; the sequence must start over.
        bus_write(2'd2, 32'h0000_0003, 4'b0001);
        for (int m = 0; m < 12; m++) begin
            @(posedge Clock);
            #1;
            checks++;
            if (Tube[0] !== exp_seq[m]) begin
                errors++;
                $display("FAIL blink_restart[%0d]: got %b expected %b", m + 1, Tube[0], exp_seq[m]);
            end
        end
    endtask

    task automatic test_expiry_collision();
        logic exp_pre  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic exp_post [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        bus_write(2'd2, 32'h0000_0002, 4'b1111);
        for (int m = 0; m < 4; m++) begin
            @(posedge Clock);
            #1;
            checks++;
            if (Tube[0] !== exp_pre[m]) begin
                errors++;
                $display("FAIL coll_pre[%0d]: got %b expected %b", m + 1, Tube[0], exp_pre[m]);
            end
        end
        // This write coincides with a counter expiry.
        bus_write(2'd2, 32'h0000_0002, 4'b0001);
        checks++;
        if (Tube[0] !== 1'b0) begin
            errors++;
            $display("FAIL coll_edge: got %b expected 0", Tube[0]);
        end
        for (int m = 0; m < 4; m++) begin
            @(posedge Clock);
            #1;
            checks++;
            if (Tube[0] !== exp_post[m]) begin
                errors++;
                $display("FAIL coll_post[%0d]: got %b expected %b", m + 1, Tube[0], exp_post[m]);
            end
        end
    endtask

    task automatic test_pwm();
        int duties [4] = '{64, 0, 255, 1};
        int lit_exp [4] = '{64, 0, 256, 1};
        bus_write(2'd2, 32'h0, 4'b1111);
        for (int t = 0; t < 4; t++) begin
            int lit_cnt;
            lit_cnt = 0;
            bus_write(2'd3, 32'(duties[t]), 4'b0001);
            @(posedge Clock);
            #1;
            for (int i = 0; i < 256; i++) begin
                @(posedge Clock);
                #1;
                if (Tube[0] === 1'b0) lit_cnt++;
            end
            checks++;
            if (lit_cnt != lit_exp[t]) begin
                errors++;
                $display("FAIL pwm_duty_%0d: lit %0d cycles expected %0d", duties[t], lit_cnt, lit_exp[t]);
            end
        end
        bus_write(2'd3, 32'h0000_00FF, 4'b0001);
    endtask

    task automatic test_reset_priority();
        logic [31:0] exp_rd [4] = '{32'h0, 32'h0, 32'h0, 32'h0000_00FF};
        bus_write(2'd0, 32'h0000_0001, 4'b1111);
        bus_write(2'd2, 32'h0000_0003, 4'b1111);
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
        Addr  = 2'd0;
        WD    = 32'hFFFF_FFFF;
        BE    = 4'b1111;
        WE    = 1'b1;
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        WE    = 1'b0;
        BE    = 4'b0000;
        checks++;
        if (Tube !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL rst_prio_tube: got %h expected ffffffff", Tube);
        end
        for (int i = 0; i < 4; i++) begin
            Addr = 2'(i);
            #1;
            checks++;
            if (RD !== exp_rd[i]) begin
                errors++;
                $display("FAIL rst_prio_rd[%0d]: got %h expected %h", i, RD, exp_rd[i]);
            end
        end
        @(posedge Clock);
        #1;
        checks++;
        if (Tube !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL rst_prio_tube_next: got %h expected ffffffff", Tube);
        end
    endtask

    initial begin
        test_reset();
        test_byte_write();
        test_blink();
        test_expiry_collision();
        test_pwm();
        test_reset_priority();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
